// File: rtl/ibex_icache_fetch_mon_pkg.sv
// ---------------------------------------------------------------------------
// ibex_icache_fetch_mon_pkg
//
// Shared definitions for the icache fetch-interface monitor:
//   - viol_e        : bit index of each violation flag in viol_o
//   - NumViol       : number of violation flags
//   - snap_t        : snapshot of the bus held while a handshake is pending
//   - is_compressed : true when a fetched word starts a 16-bit instruction
//   - wd_cnt_w      : counter width needed by the stall watchdog
//
// Optional feature macro used by the monitor: IBEX_ICACHE_FETCH_MON_ADDR_CHK_EN
// ---------------------------------------------------------------------------
package ibex_icache_fetch_mon_pkg;

   typedef enum logic [3:0] {
      ViolReadyNoReq         = 4'd0,
      ViolBranchMisaligned   = 4'd1,
      ViolBranchNoSpec       = 4'd2,
      ViolFetchNoAddr        = 4'd3,
      ViolValidDropped       = 4'd4,
      ViolAddrUnstable       = 4'd5,
      ViolErrUnstable        = 4'd6,
      ViolRDataUnstable      = 4'd7,
      ViolErrPlus2Compressed = 4'd8,
      ViolAddrMismatch       = 4'd9,
      ViolTimeout            = 4'd10
   } viol_e;

   localparam int unsigned NumViol = 11;

   // The snapshot address field is sized for the widest supported bus; the
   // monitor zero-extends its AddrW-bit address into it.
   localparam int unsigned SnapAddrW = 64;

   typedef struct packed {
      logic [SnapAddrW-1:0] addr;
      logic                 err;
      logic                 err_plus2;
      logic [31:0]          rdata;
      logic                 compressed;
   } snap_t;

   function automatic logic is_compressed(input logic [31:0] rdata);
      return rdata[1:0] != 2'b11;
   endfunction

   // Width able to hold 0..t inclusive, never less than one bit.
   function automatic int unsigned wd_cnt_w(input int unsigned t);
      return (t < 2) ? 1 : $clog2(t + 1);
   endfunction

endpackage

// File: rtl/ibex_icache_fetch_mon_watchdog.sv
// ---------------------------------------------------------------------------
// ibex_icache_fetch_mon_watchdog
//
// Counts consecutive stall cycles and raises a single-cycle fire pulse on the
// TimeoutCycles-th consecutive stall cycle. The count then holds at the limit
// until a non-stall cycle zeroes it, so one stall episode fires only once.
// TimeoutCycles = 0 removes the counter and fire stays low.
//
// Ports:
//   clk    in   clock
//   rst_n  in   async active-low reset
//   stall  in   current cycle is a stall cycle
//   fire   out  combinational pulse: this stall cycle reaches the limit
// ---------------------------------------------------------------------------
module ibex_icache_fetch_mon_watchdog
   import ibex_icache_fetch_mon_pkg::*;
#(
   parameter int unsigned TimeoutCycles = 256
) (
   input  logic clk,
   input  logic rst_n,
   input  logic stall,
   output logic fire
);

   localparam int unsigned CntBits = wd_cnt_w(TimeoutCycles);

   generate
      if (TimeoutCycles == 0) begin : g_off
         logic unused_wd;
         assign unused_wd = ^{clk, rst_n, stall};
         assign fire      = 1'b0;
      end else begin : g_on
         localparam logic [CntBits-1:0] Limit   = CntBits'(TimeoutCycles);
         localparam logic [CntBits-1:0] LimitM1 = CntBits'(TimeoutCycles - 1);
         localparam logic [CntBits-1:0] One     = CntBits'(1);

         logic [CntBits-1:0] cnt_p1;

         // stage p1: consecutive stall count, saturating at the limit
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               cnt_p1 <= '0;
            end else if (!stall) begin
               cnt_p1 <= '0;
            end else if (cnt_p1 != Limit) begin
               cnt_p1 <= cnt_p1 + One;
            end
         end

         assign fire = stall && (cnt_p1 == LimitM1);
      end
   endgenerate

endmodule

// File: rtl/ibex_icache_fetch_monitor.sv
// ---------------------------------------------------------------------------
// ibex_icache_fetch_monitor
//
// Passive, synthesizable checker for the icache-to-core fetch interface.
// Every rule is evaluated on the bus sample at a clock edge and reported one
// cycle later as a registered, one-cycle pulse on its own viol_o bit. Any
// violating cycle also sets a sticky flag and bumps a saturating counter.
//
// Optional feature: define IBEX_ICACHE_FETCH_MON_ADDR_CHK_EN to compile in
// expected-address tracking and the AddrMismatch rule. Without it exp_addr_o
// is 0 and AddrMismatch never fires.
//
// Parameters:
//   AddrW          address width
//   CntW           violation counter width
//   TimeoutCycles  stall cycles before Timeout fires (0 disables)
//
// Ports:
//   clk, rst_n              clock, async active-low reset
//   req, branch, branch_spec, ready, valid, err, err_plus2   bus controls
//   branch_addr, addr       bus addresses
//   rdata                   fetched data
//   clear                   sync clear of sticky flag and counter
//   viol_o                  per-rule violation pulse (index = viol_e)
//   viol_sticky_o           any violation since reset/clear
//   viol_count_o            saturating count of violating cycles
//   exp_addr_o              address the next good response must carry
// ---------------------------------------------------------------------------
module ibex_icache_fetch_monitor
   import ibex_icache_fetch_mon_pkg::*;
#(
   parameter int unsigned AddrW         = 32,
   parameter int unsigned CntW          = 16,
   parameter int unsigned TimeoutCycles = 256
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               req,
   input  logic               branch,
   input  logic               branch_spec,
   input  logic [AddrW-1:0]   branch_addr,
   input  logic               ready,
   input  logic               valid,
   input  logic [AddrW-1:0]   addr,
   input  logic [31:0]        rdata,
   input  logic               err,
   input  logic               err_plus2,
   input  logic               clear,
   output logic [NumViol-1:0] viol_o,
   output logic               viol_sticky_o,
   output logic [CntW-1:0]    viol_count_o,
   output logic [AddrW-1:0]   exp_addr_o
);

   localparam logic [CntW-1:0] CntMax = '1;
   localparam logic [CntW-1:0] CntOne = CntW'(1);

   logic                 has_addr;
   logic                 has_addr_d;
   logic                 pend;
   logic                 pend_d;
   logic [SnapAddrW-1:0] addr_ext;
   snap_t                snap_d;
   snap_t                snap_p1;
   logic                 good_hs;
   logic                 addr_mismatch;
   logic                 stall;
   logic                 wd_fire;
   logic [NumViol-1:0]   viol_d;
   logic                 any_viol;

   // ---------------------------------------------------------------------
   // Bus tracking: has_addr says a fetch address is outstanding (set by a
   // branch, dropped by an error response). pend marks a response that was
   // offered but not yet taken, whose bus values must be held.
   // ---------------------------------------------------------------------
   always_comb begin
      addr_ext             = '0;
      addr_ext[AddrW-1:0]  = addr;
      snap_d.addr          = addr_ext;
      snap_d.err           = err;
      snap_d.err_plus2     = err_plus2;
      snap_d.rdata         = rdata;
      snap_d.compressed    = is_compressed(rdata);

      has_addr_d = has_addr;
      if (branch) begin
         has_addr_d = 1'b1;
      end else if (err && valid && ready) begin
         has_addr_d = 1'b0;
      end

      pend_d  = has_addr && valid && !(ready || branch);
      good_hs = valid && ready && !branch && !err && has_addr;
      stall   = has_addr && ready && !valid && !branch;
   end

   // stage p1: control state
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         has_addr <= 1'b0;
         pend     <= 1'b0;
      end else begin
         has_addr <= has_addr_d;
         pend     <= pend_d;
      end
   end

   // stage p1: snapshot data; only ever read while pend is set, so it needs
   // no reset and a reset mid-stall simply abandons it.
   always_ff @(posedge clk) begin
      if (pend_d) begin
         snap_p1 <= snap_d;
      end
   end

`ifdef IBEX_ICACHE_FETCH_MON_ADDR_CHK_EN
   logic [AddrW-1:0] exp_addr;

   // stage p1: expected address; a branch overrides any same-cycle beat
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         exp_addr <= '0;
      end else if (branch) begin
         exp_addr <= branch_addr;
      end else if (good_hs) begin
         exp_addr <= exp_addr + (is_compressed(rdata) ? AddrW'(2) : AddrW'(4));
      end
   end

   assign addr_mismatch = good_hs && (addr != exp_addr);
   assign exp_addr_o    = exp_addr;
`else
   logic unused_addr_chk;
   assign unused_addr_chk = ^{branch_addr[AddrW-1:1], good_hs};
   assign addr_mismatch   = 1'b0;
   assign exp_addr_o      = '0;
`endif

   ibex_icache_fetch_mon_watchdog #(
      .TimeoutCycles (TimeoutCycles)
   ) u_watchdog (
      .clk   (clk),
      .rst_n (rst_n),
      .stall (stall),
      .fire  (wd_fire)
   );

   // ---------------------------------------------------------------------
   // Rule evaluation on the current bus sample
   // ---------------------------------------------------------------------
   always_comb begin
      viol_d = '0;

      if (pend) begin
         viol_d[ViolValidDropped] = !valid;
         viol_d[ViolAddrUnstable] = addr_ext != snap_p1.addr;
         viol_d[ViolErrUnstable]  = (err != snap_p1.err) ||
                                    (err_plus2 != snap_p1.err_plus2);
         // Error responses carry no meaningful data. A compressed
         // instruction only guarantees the low half-word.
         if (!snap_p1.err) begin
            viol_d[ViolRDataUnstable] =
               (rdata[15:0] != snap_p1.rdata[15:0]) ||
               (!snap_p1.compressed && (rdata[31:16] != snap_p1.rdata[31:16]));
         end
      end

      viol_d[ViolReadyNoReq]         = ready && !req;
      viol_d[ViolBranchMisaligned]   = branch && branch_addr[0];
      viol_d[ViolBranchNoSpec]       = branch && !branch_spec;
      viol_d[ViolFetchNoAddr]        = ready && !(branch || has_addr);
      viol_d[ViolErrPlus2Compressed] = valid && err && err_plus2 &&
                                       (rdata[1:0] != 2'b11);
      viol_d[ViolAddrMismatch]       = addr_mismatch;
      viol_d[ViolTimeout]            = wd_fire;

      any_viol = |viol_d;
   end

   // stage p1: reported results; a new violation beats a same-cycle clear
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         viol_o        <= '0;
         viol_sticky_o <= 1'b0;
         viol_count_o  <= '0;
      end else begin
         viol_o <= viol_d;
         if (any_viol) begin
            viol_sticky_o <= 1'b1;
            if (clear) begin
               viol_count_o <= CntOne;
            end else if (viol_count_o != CntMax) begin
               viol_count_o <= viol_count_o + CntOne;
            end
         end else if (clear) begin
            viol_sticky_o <= 1'b0;
            viol_count_o  <= '0;
         end
      end
   end

endmodule
